axil_ram_slave: RTL and testbench

AXIL_RAM_SLAVE -- requirements
Module: axil_ram_slave

---
 rtl/axil_ram_slave_if.sv | 33 +++
 rtl/axil_ram_slave.sv | 178 +++++++++++++++++
 tb/tb_axil_ram_slave.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_ram_slave_if.sv
// AXI-Lite style bus for the RAM slave: AR/R read channels, AW/W write channels,
// no B channel and no write strobes.
interface axil_ram_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic                  RVALID;
  logic                  RREADY;
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic                  WVALID;
  logic                  WREADY;

  modport slave (
    input  ARADDR, ARVALID, output ARREADY,
    output RDATA, RVALID, input RREADY,
    input  AWADDR, AWVALID, output AWREADY,
    input  WDATA, WVALID, output WREADY
  );

  modport master (
    output ARADDR, ARVALID, input ARREADY,
    input  RDATA, RVALID, output RREADY,
    output AWADDR, AWVALID, input AWREADY,
    output WDATA, WVALID, input WREADY
  );
endinterface

// File: rtl/axil_ram_slave.sv
// Single-port-per-direction word RAM behind an AXI-Lite style slave; read data returns
// 1+RD_WAIT cycles after AR, held under RREADY backpressure; one read and one write in flight.
module axil_ram_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int RD_WAIT    = 0
) (
  input  logic             clk,
  input  logic             rst,
  axil_ram_slave_if.slave  bus
);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [3:0] RD_WAIT_C = 4'(RD_WAIT);

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_COMMIT} wstate_e;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  rstate_e               rstate_q, rstate_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  idx_t                  raddr_q, raddr_d;
  logic [3:0]            rcnt_q, rcnt_d;

  wstate_e               wstate_q, wstate_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  idx_t                  waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  idx_t ar_idx, aw_idx;
  logic aw_hs, w_hs, mem_we;
  logic unused_addr_bits;

  // Only the word index matters; upper and byte-lane address bits alias.
  assign ar_idx = bus.ARADDR[IDX_W+1:2];
  assign aw_idx = bus.AWADDR[IDX_W+1:2];
  assign unused_addr_bits = ^{bus.ARADDR, bus.AWADDR};

  assign aw_hs  = bus.AWVALID && awready_q;
  assign w_hs   = bus.WVALID && wready_q;
  assign mem_we = (wstate_q == W_COMMIT);

  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    raddr_d   = raddr_q;
    rcnt_d    = rcnt_q;
    case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (bus.ARVALID && arready_q) begin
          raddr_d   = ar_idx;
          arready_d = 1'b0;
          if (RD_WAIT != 0) begin
            rstate_d = R_WAIT;
            rcnt_d   = RD_WAIT_C;
          end else begin
            rstate_d = R_DATA;
            rvalid_d = 1'b1;
            rdata_d  = mem[ar_idx];
          end
        end
      end
      R_WAIT: begin
        if (rcnt_q <= 4'd1) begin
          rstate_d = R_DATA;
          rvalid_d = 1'b1;
          rdata_d  = mem[raddr_q];
          rcnt_d   = 4'd0;
        end else begin
          rcnt_d = rcnt_q - 4'd1;
        end
      end
      R_DATA: begin
        if (bus.RREADY) begin
          rstate_d  = R_IDLE;
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    wstate_d  = wstate_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    case (wstate_q)
      W_IDLE: begin
        awready_d = 1'b1;
        wready_d  = 1'b1;
        if (aw_hs) waddr_d = aw_idx;
        if (w_hs)  wdata_d = bus.WDATA;
        if (aw_hs && w_hs) begin
          wstate_d  = W_COMMIT;
          awready_d = 1'b0;
          wready_d  = 1'b0;
        end else if (aw_hs) begin
          wstate_d  = W_ADDR;
          awready_d = 1'b0;
        end else if (w_hs) begin
          wstate_d = W_DATA;
          wready_d = 1'b0;
        end
      end
      W_ADDR: begin
        if (w_hs) begin
          wdata_d  = bus.WDATA;
          wstate_d = W_COMMIT;
          wready_d = 1'b0;
        end
      end
      W_DATA: begin
        if (aw_hs) begin
          waddr_d   = aw_idx;
          wstate_d  = W_COMMIT;
          awready_d = 1'b0;
        end
      end
      W_COMMIT: begin
        wstate_d  = W_IDLE;
        awready_d = 1'b1;
        wready_d  = 1'b1;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      raddr_q   <= '0;
      rcnt_q    <= 4'd0;
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      raddr_q   <= raddr_d;
      rcnt_q    <= rcnt_d;
      wstate_q  <= wstate_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  // Storage is deliberately outside reset so contents survive it; a read sampling
  // the committing word on the same edge sees the old value.
  always_ff @(posedge clk) begin
    if (mem_we) mem[waddr_q] <= wdata_q;
  end

  assign bus.ARREADY = arready_q;
  assign bus.RVALID  = rvalid_q;
  assign bus.RDATA   = rdata_q;
  assign bus.AWREADY = awready_q;
  assign bus.WREADY  = wready_q;
endmodule

// File: tb/tb_axil_ram_slave.sv
// Bench for axil_ram_slave: two instances (RD_WAIT 0 and 3) exercised in turn through
// a shared driver, checked against a word-array model of the RAM.
module tb_axil_ram_slave;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axil_ram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
  axil_ram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus3 ();

  axil_ram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(1024), .RD_WAIT(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  axil_ram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(1024), .RD_WAIT(3))
    dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  logic        sel;
  logic [31:0] araddr, awaddr, wdata;
  logic        arvalid, rready, awvalid, wvalid;
  logic        arready, rvalid, awready, wready;
  logic [31:0] rdata;

  assign bus0.ARADDR  = araddr;
  assign bus0.ARVALID = arvalid & ~sel;
  assign bus0.RREADY  = rready & ~sel;
  assign bus0.AWADDR  = awaddr;
  assign bus0.AWVALID = awvalid & ~sel;
  assign bus0.WDATA   = wdata;
  assign bus0.WVALID  = wvalid & ~sel;
  assign bus3.ARADDR  = araddr;
  assign bus3.ARVALID = arvalid & sel;
  assign bus3.RREADY  = rready & sel;
  assign bus3.AWADDR  = awaddr;
  assign bus3.AWVALID = awvalid & sel;
  assign bus3.WDATA   = wdata;
  assign bus3.WVALID  = wvalid & sel;

  assign arready = sel ? bus3.ARREADY : bus0.ARREADY;
  assign rvalid  = sel ? bus3.RVALID  : bus0.RVALID;
  assign rdata   = sel ? bus3.RDATA   : bus0.RDATA;
  assign awready = sel ? bus3.AWREADY : bus0.AWREADY;
  assign wready  = sel ? bus3.WREADY  : bus0.WREADY;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] mdl [2][1024];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h (dut RD_WAIT=%0d)", tag, got, exp, rdw());
    end
  endtask

  function automatic int rdw();
    return sel ? 3 : 0;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int ch, input string tag);
    bit   ok;
    logic r;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      r = (ch == 0) ? arready : (ch == 1) ? awready : wready;
      tick();
      ok = r;
    end
    if (!ok) chk({tag, "_hs_timeout"}, 32'd0, 32'd1);
  endtask

  // mode 0: AW and W together; 1: W first; 2: AW first. A stray VALID pulse on the
  // already-accepted channel during the gap must be ignored.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int mode, input int gap);
    if (mode == 0) begin
      awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
      wait_ready(1, "wr_both");
      awvalid = 1'b0; wvalid = 1'b0;
    end else if (mode == 1) begin
      wdata = d; wvalid = 1'b1;
      wait_ready(2, "wr_w");
      wvalid = 1'b0;
      for (int i = 0; i < gap; i++) begin
        chk("wdata_awready", 32'(awready), 32'd1);
        chk("wdata_wready", 32'(wready), 32'd0);
        wvalid = (i == 0); wdata = (i == 0) ? ~d : d;
        tick();
      end
      wvalid = 1'b0; wdata = d;
      awaddr = a; awvalid = 1'b1;
      wait_ready(1, "wr_aw");
      awvalid = 1'b0;
    end else begin
      awaddr = a; awvalid = 1'b1;
      wait_ready(1, "wr_aw");
      awvalid = 1'b0;
      for (int i = 0; i < gap; i++) begin
        chk("waddr_awready", 32'(awready), 32'd0);
        chk("waddr_wready", 32'(wready), 32'd1);
        awvalid = (i == 0); awaddr = (i == 0) ? a + 32'h40 : a;
        tick();
      end
      awvalid = 1'b0; awaddr = a;
      wdata = d; wvalid = 1'b1;
      wait_ready(2, "wr_w");
      wvalid = 1'b0;
    end
    chk("commit_awready", 32'(awready), 32'd0);
    chk("commit_wready", 32'(wready), 32'd0);
    tick();
    chk("widle_awready", 32'(awready), 32'd1);
    chk("widle_wready", 32'(wready), 32'd1);
    mdl[sel][widx(a)] = d;
  endtask

  task automatic do_read(input logic [31:0] a, input int hold);
    int lat;
    logic [31:0] exp;
    exp = mdl[sel][widx(a)];
    araddr = a; arvalid = 1'b1;
    wait_ready(0, "rd_ar");
    arvalid = 1'b0;
    chk("rd_busy_arready", 32'(arready), 32'd0);
    lat = 0;
    while (!rvalid && lat < 40) begin
      tick();
      lat++;
    end
    chk("rd_latency", lat, rdw());
    chk("rd_data", rdata, exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("rd_hold_rvalid", 32'(rvalid), 32'd1);
      chk("rd_hold_rdata", rdata, exp);
      chk("rd_hold_arready", 32'(arready), 32'd0);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("rd_done_rvalid", 32'(rvalid), 32'd0);
    chk("rd_done_arready", 32'(arready), 32'd1);
  endtask

  // Arrange for the write commit edge to coincide with the edge that enters R_DATA.
  task automatic collide();
    int w, ar_c, wr_c, last, lat;
    do_write(32'h40, 32'h1, 0, 0);
    w = rdw();
    ar_c = (w == 0) ? 1 : 0;
    wr_c = ar_c + w - 1;
    last = (ar_c > wr_c) ? ar_c : wr_c;
    araddr = 32'h40; awaddr = 32'h40; wdata = 32'h2;
    for (int c = 0; c <= last; c++) begin
      arvalid = (c == ar_c);
      awvalid = (c == wr_c);
      wvalid  = (c == wr_c);
      tick();
    end
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 40) begin
      tick();
      lat++;
    end
    chk("coll_rvalid", 32'(rvalid), 32'd1);
    chk("coll_old_data", rdata, 32'h1);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    mdl[sel][widx(32'h40)] = 32'h2;
    do_read(32'h40, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_arready"}, 32'(arready), 32'd0);
    chk({tag, "_awready"}, 32'(awready), 32'd0);
    chk({tag, "_wready"}, 32'(wready), 32'd0);
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
  endtask

  task automatic reset_midop();
    do_write(32'h8, 32'hC0FFEE00 | 32'(sel), 0, 0);
    araddr = 32'h8; arvalid = 1'b1;
    awaddr = 32'h8; awvalid = 1'b1;
    wait_ready(1, "rst_aw");
    arvalid = 1'b0; awvalid = 1'b0;
    chk("rst_pre_awready", 32'(awready), 32'd0);
    rst = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    tick();
    tick();
    chk_reset_outputs("rst_hold");
    rst = 1'b1;
    #1;
    chk("rst_rel_arready", 32'(arready), 32'd0);
    tick();
    chk("rst_up_arready", 32'(arready), 32'd1);
    chk("rst_up_awready", 32'(awready), 32'd1);
    chk("rst_up_wready", 32'(wready), 32'd1);
    for (int i = 0; i < rdw() + 3; i++) begin
      tick();
      chk("rst_no_rvalid", 32'(rvalid), 32'd0);
    end
    do_read(32'h8, 1);
  endtask

  task automatic random_phase();
    logic [31:0] a, hi;
    for (int i = 0; i < 16; i++)
      do_write(32'h100 + 32'(i * 4), $urandom, int'($urandom_range(0, 2)), 1);
    for (int n = 0; n < 40; n++) begin
      hi = $urandom;
      a = (hi & 32'hFFFF_F003) | (32'h100 + 32'($urandom_range(0, 15)) * 32'd4);
      if ($urandom_range(0, 1) == 0)
        do_write(a, $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      else
        do_read(a, int'($urandom_range(0, 4)));
    end
  endtask

  initial begin
    sel = 1'b0; araddr = '0; awaddr = '0; wdata = '0;
    arvalid = 1'b0; rready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      mdl[0][i] = '0;
      mdl[1][i] = '0;
    end
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk_reset_outputs("por");
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("por_up_arready", 32'(arready), 32'd1);
      chk("por_up_awready", 32'(awready), 32'd1);
      chk("por_up_wready", 32'(wready), 32'd1);
    end
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      tick();
      do_write(32'h10, 32'hDEADBEEF, 0, 0);
      do_read(32'h10, 0);
      do_write(32'h24, 32'h12345678, 1, 2);
      do_read(32'h24, 0);
      do_read(32'h24, 5);
      do_write(32'h1004, 32'hA5A5A5A5, 2, 2);
      do_read(32'h0004, 0);
      do_read(32'h0006, 1);
      collide();
      reset_midop();
      random_phase();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
